// File: rtl/stage2_writeback_if.sv
// SRAM write port of the stage-2 write-back: valid/ready with bank, word address, data and lane mask.
interface stage2_writeback_if #(
    parameter int WIDTH    = 16,
    parameter int PARALLEL = 2,
    parameter int ADDR_W   = 12
);
    logic                        wr_en;
    logic                        wr_ready;
    logic [2:0]                  wr_bank;
    logic [ADDR_W-1:0]           wr_addr;
    logic [2*PARALLEL*WIDTH-1:0] wr_data;
    logic [2*PARALLEL-1:0]       wr_mask;

    modport master (output wr_en, wr_bank, wr_addr, wr_data, wr_mask, input wr_ready);
    modport slave  (input wr_en, wr_bank, wr_addr, wr_data, wr_mask, output wr_ready);
endinterface

// File: rtl/stage2_writeback.sv
// Stage-2 write-back: buffers pipe beats in a small FIFO and drains them to the SRAM write port.
// Define STAGE2_WB_FILTER_EN to drop stage-6 lanes carrying the "no centre" id.
module stage2_wb_lane #(
    parameter int WIDTH      = 16,
    parameter int N_SENTINEL = 4096,
    parameter bit FILTER     = 1'b0
) (
    input  logic [WIDTH-1:0] op1,
    input  logic             is_s6,
    output logic             m1,
    output logic             m2
);
    logic keep;
    assign keep = !(FILTER && is_s6 && (op1 == WIDTH'(N_SENTINEL)));
    assign m1   = keep;
    assign m2   = keep && is_s6;
endmodule

module stage2_writeback #(
    parameter int WIDTH      = 16,
    parameter int PARALLEL   = 2,
    parameter int ADDR_W     = 12,
    parameter int DEPTH      = 4,
    parameter int N_SENTINEL = 4096
) (
    input  logic                             CLK_i,
    input  logic                             RST_i,
    input  logic                             clear_i,
    input  logic                             valid_i,
    input  logic [2:0]                       stage_i,
    input  logic                             finished_i,
    input  logic [PARALLEL-1:0][WIDTH-1:0]   operand1_i,
    input  logic [PARALLEL-1:0][WIDTH-1:0]   operand2_i,
    output logic                             stall_o,
    stage2_writeback_if.master               wr,
    output logic                             done_o,
    output logic                             overflow_o
);
`ifdef STAGE2_WB_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [2:0]                  bank;
        logic [ADDR_W-1:0]           addr;
        logic [2*PARALLEL*WIDTH-1:0] data;
        logic [2*PARALLEL-1:0]       mask;
    } entry_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [ADDR_W-1:0] addr_q, beat_addr;
    logic [2:0]        last_stage_q;
    logic              run_phase, beat_ok, pop, do_push, ovf_set, any_mask;
    logic [PARALLEL-1:0] mask1, mask2;
    logic [2*PARALLEL-1:0] new_mask;

    for (genvar i = 0; i < PARALLEL; i++) begin : g_lane
        stage2_wb_lane #(.WIDTH(WIDTH), .N_SENTINEL(N_SENTINEL), .FILTER(FILTER)) u_lane (
            .op1  (operand1_i[i]),
            .is_s6(stage_i == 3'd6),
            .m1   (mask1[i]),
            .m2   (mask2[i])
        );
    end

    assign new_mask  = {mask2, mask1};
    assign any_mask  = |new_mask;
    assign beat_ok   = run_phase && valid_i && (stage_i != 3'd7);
    assign beat_addr = (stage_i != last_stage_q) ? '0 : addr_q;
    assign pop       = wr.wr_en && wr.wr_ready;
    // A full FIFO still takes the beat if the head leaves on the same edge.
    assign do_push   = beat_ok && any_mask && ((count_q != CW'(DEPTH)) || pop);
    assign ovf_set   = beat_ok && any_mask && (count_q == CW'(DEPTH)) && !pop;

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            last_stage_q <= '0;
            overflow_o   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else if (clear_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            last_stage_q <= '0;
        end else begin
            if (do_push) begin
                fifo_q[wr_ptr_q] <= '{bank: stage_i, addr: beat_addr,
                                      data: {operand2_i, operand1_i}, mask: new_mask};
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(pop);
            // Dropped and filtered beats still consume their address slot.
            if (beat_ok) begin
                addr_q       <= beat_addr + ADDR_W'(PARALLEL);
                last_stage_q <= stage_i;
            end
            if (ovf_set) overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) state_d = IDLE;
        else begin
            case (state_q)
                IDLE:    if (valid_i) state_d = RUN;
                RUN:     if (finished_i || stage_i == 3'd7) state_d = DRAIN;
                DRAIN:   if (count_q == '0) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        run_phase = (state_q == IDLE) || (state_q == RUN);
        done_o    = (state_q == DONE);
    end

    assign stall_o    = (count_q >= CW'(DEPTH - 1));
    assign wr.wr_en   = (count_q != '0);
    assign wr.wr_bank = fifo_q[rd_ptr_q].bank;
    assign wr.wr_addr = fifo_q[rd_ptr_q].addr;
    assign wr.wr_data = fifo_q[rd_ptr_q].data;
    assign wr.wr_mask = fifo_q[rd_ptr_q].mask;
endmodule

// File: tb/tb_stage2_writeback.sv
// Scoreboard bench for stage2_writeback: expected writes are queued as beats are driven and
// compared when the SRAM port accepts them.
module tb_stage2_writeback;
  localparam int WIDTH = 16, PARALLEL = 2, ADDR_W = 12, DEPTH = 4;

  typedef struct {
    logic [2:0]  bank;
    logic [11:0] addr;
    logic [63:0] data;
    logic [3:0]  mask;
  } ent_t;

  logic CLK_i = 0, RST_i = 1, clear_i = 0, valid_i = 0, finished_i = 0;
  logic [2:0] stage_i = '0;
  logic [PARALLEL-1:0][WIDTH-1:0] operand1_i = '0, operand2_i = '0;
  logic stall_o, done_o, overflow_o;

  stage2_writeback_if #(.WIDTH(WIDTH), .PARALLEL(PARALLEL), .ADDR_W(ADDR_W)) wb ();

  stage2_writeback #(.WIDTH(WIDTH), .PARALLEL(PARALLEL), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
                     .N_SENTINEL(4096)) dut (
    .CLK_i(CLK_i), .RST_i(RST_i), .clear_i(clear_i), .valid_i(valid_i), .stage_i(stage_i),
    .finished_i(finished_i), .operand1_i(operand1_i), .operand2_i(operand2_i),
    .stall_o(stall_o), .wr(wb), .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 CLK_i = ~CLK_i;

  int n_chk = 0, n_pass = 0;
  ent_t q[$];
  int m_state = 0;
  logic [11:0] m_addr = '0;
  logic [2:0]  m_last = '0;
  bit m_ovf = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] exp_mask(input logic [2:0] st, input logic [31:0] op1);
    logic [3:0] m;
    m = (st == 3'd6) ? 4'b1111 : 4'b0011;
`ifdef STAGE2_WB_FILTER_EN
    for (int i = 0; i < 2; i++)
      if (st == 3'd6 && op1[i*16 +: 16] == 16'd4096) begin m[i] = 1'b0; m[i+2] = 1'b0; end
`endif
    return m;
  endfunction

  task automatic chk_outs();
    chk("wr_en", wb.wr_en, q.size() != 0);
    chk("stall", stall_o, q.size() >= DEPTH - 1);
    chk("overflow", overflow_o, m_ovf);
    chk("done", done_o, m_state == 3);
  endtask

  // Called at a negedge with inputs set; models the coming edge, then samples at the next negedge.
  task automatic tick();
    int sz;
    bit pop;
    ent_t e;
    logic [11:0] a;
    logic [3:0] mk;
    sz  = q.size();
    pop = (sz != 0) && wb.wr_ready;
    if (pop) begin
      e = q.pop_front();
      chk("wr_bank", wb.wr_bank, e.bank);
      chk("wr_addr", wb.wr_addr, e.addr);
      chk("wr_data", wb.wr_data, e.data);
      chk("wr_mask", wb.wr_mask, e.mask);
    end
    if (clear_i) begin
      q.delete(); m_state = 0; m_addr = '0; m_last = '0;
    end else begin
      if (m_state <= 1 && valid_i && stage_i != 3'd7) begin
        a  = (stage_i != m_last) ? 12'd0 : m_addr;
        mk = exp_mask(stage_i, operand1_i);
        if (mk != 4'b0) begin
          if (sz < DEPTH || pop) begin
            e.bank = stage_i; e.addr = a; e.data = {operand2_i, operand1_i}; e.mask = mk;
            q.push_back(e);
          end else m_ovf = 1;
        end
        m_addr = a + 12'd2;
        m_last = stage_i;
      end
      case (m_state)
        0: if (valid_i) m_state = 1;
        1: if (finished_i || stage_i == 3'd7) m_state = 2;
        2: if (sz == 0) m_state = 3;
        default: ;
      endcase
    end
    @(posedge CLK_i);
    @(negedge CLK_i);
    chk_outs();
  endtask

  task automatic beat(input logic [2:0] st, input logic [31:0] op1, input logic [31:0] op2,
                      input logic fin);
    valid_i = 1; stage_i = st; operand1_i = op1; operand2_i = op2; finished_i = fin;
    tick();
    valid_i = 0; finished_i = 0;
  endtask

  task automatic idle(input int n);
    valid_i = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    wb.wr_ready = 1;
    #2 chk_outs();
    @(negedge CLK_i); RST_i = 0;
    tick();

    // stage 0: consecutive beats at 0,2,4
    for (int i = 0; i < 3; i++) beat(3'd0, $urandom, $urandom, 1'b0);
    idle(2);
    // stage 1 up to addr 6, then stage 2 restarts at 0
    for (int i = 0; i < 4; i++) beat(3'd1, $urandom, $urandom, 1'b0);
    beat(3'd2, 32'h0001_0002, 32'h0003_0004, 1'b0);
    beat(3'd2, 32'h0005_0006, 32'h0007_0008, 1'b0);
    idle(2);

    // back-pressure: fill, in-flight beat, then overflow drops
    wb.wr_ready = 0;
    for (int i = 0; i < 6; i++) beat(3'd3, $urandom, $urandom, 1'b0);
    wb.wr_ready = 1;
    idle(6);

    // stage 6 masks and sentinel handling
    beat(3'd5, $urandom, $urandom, 1'b0);
    beat(3'd6, {16'd4096, 16'd4096}, {16'h1111, 16'h2222}, 1'b0);
    beat(3'd6, {16'd4096, 16'd7}, {16'h1234, 16'h3C00}, 1'b0);
    beat(3'd6, {16'd9, 16'd4096}, {16'h5555, 16'h6666}, 1'b0);
    idle(3);

    // finish with two queued entries and a toggling ready
    wb.wr_ready = 0;
    beat(3'd4, 32'hAAAA_BBBB, 32'hCCCC_DDDD, 1'b0);
    beat(3'd4, 32'h1212_3434, 32'h5656_7878, 1'b1);
    for (int i = 0; i < 6; i++) begin
      wb.wr_ready = i[0];
      if (i == 2) begin valid_i = 1; stage_i = 3'd4; end
      tick();
      valid_i = 0;
    end
    wb.wr_ready = 1;
    idle(2);
    chk("done_after_drain", done_o, 1'b1);
    wb.wr_ready = 0;
    clear_i = 1; tick(); clear_i = 0;
    tick();
    chk("done_after_clear", done_o, 1'b0);

    // asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) beat(3'd2, $urandom, $urandom, 1'b0);
    #2 RST_i = 1;
    #1;
    chk("rst_wr_en", wb.wr_en, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_overflow", overflow_o, 1'b0);
    q.delete(); m_state = 0; m_addr = '0; m_last = '0; m_ovf = 0;
    @(negedge CLK_i); RST_i = 0;
    wb.wr_ready = 1;
    beat(3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    chk("post_rst_addr", wb.wr_addr, 12'd0);
    beat(3'd0, 32'h0000_1111, 32'h0000_2222, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
